// File: rtl/fsm_out.sv
// Egress framer: pops a stored packet from the port FIFO and re-emits it
// as SOF, port_addr, LEN, payload; flags parity errors and underruns.
// Ports: clk, rst_n, port_addr, port_rd, fifo_empty, fifo_rd_data (in);
//   fifo_rd_en, port_valid, port_data, busy, parity_err, frame_err (out).
module fsm_out #(
  parameter int                   W_WIDTH  = 8,
  parameter logic [W_WIDTH-1:0]   SOF_BYTE = 'hFF,
  parameter int                   TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_WIDTH-1:0] port_addr,
  input  logic               port_rd,
  input  logic               fifo_empty,
  input  logic [W_WIDTH-1:0] fifo_rd_data,
  output logic               fifo_rd_en,
  output logic               port_valid,
  output logic [W_WIDTH-1:0] port_data,
  output logic               busy,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_EOF
  } state_t;

  state_t             state_q, state_d;
  logic [W_WIDTH-1:0] len_q, len_d;
  logic [W_WIDTH-1:0] xor_q, xor_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [SW-1:0]      stall_inc;
  logic               valid_q, valid_d;
  logic [W_WIDTH-1:0] data_q, data_d;
  logic               busy_q, busy_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      xor_q   <= '0;
      stall_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    xor_d      = xor_q;
    stall_d    = stall_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    busy_d     = busy_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    fifo_rd_en = 1'b0;
    stall_inc  = stall_q + SW'(1);
    unique case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (port_rd && !fifo_empty) begin
          state_d = S_SOF;
          busy_d  = 1'b1;
        end
      end
      S_SOF: begin
        valid_d = 1'b1;
        data_d  = SOF_BYTE;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        valid_d = 1'b1;
        data_d  = port_addr;
        state_d = S_LEN;
      end
      S_LEN, S_DATA: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          valid_d    = 1'b1;
          data_d     = fifo_rd_data;
          stall_d    = '0;
          if (state_q == S_LEN) begin
            len_d   = fifo_rd_data;
            xor_d   = '0;
            state_d = (fifo_rd_data == '0) ? S_EOF : S_DATA;
          end else begin
            len_d = len_q - W_WIDTH'(1);
            xor_d = xor_q ^ fifo_rd_data;
            if (len_q == W_WIDTH'(1)) state_d = S_EOF;
          end
        end else if (stall_inc == SW'(TIMEOUT)) begin
          // Underrun: abandon the frame, leftovers stay in the FIFO
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          stall_d = '0;
          state_d = S_IDLE;
        end else begin
          stall_d = stall_inc;
        end
      end
      S_EOF: begin
        perr_d  = |xor_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign port_valid = valid_q;
  assign port_data  = data_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_fsm_out.sv
// Self-checking bench for fsm_out: directed frame table, corner
// sequences and random frames against a byte-stream reference.
module tb_fsm_out;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       port_rd = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] port_addr = 8'h05;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       port_valid;
  logic [7:0] port_data;
  logic       busy;
  logic       parity_err;
  logic       frame_err;

  fsm_out #(.W_WIDTH(8), .SOF_BYTE(8'hFF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .port_addr(port_addr),
    .port_rd(port_rd), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .port_valid(port_valid), .port_data(port_data), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] fq[$];
  logic [7:0] beats[$];
  int         beat_cyc[$];
  int cyc = 0, pops = 0, pe_cnt = 0, fe_cnt = 0;
  int pe_cyc = -1, fe_cyc = -1, bad_rd = 0;
  logic rd_seen = 1'b0;
  int checks = 0, fails = 0;

  function automatic void refresh();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? 8'h00 : fq[0];
  endfunction

  always @(negedge clk) begin
    cyc++;
    rd_seen = fifo_rd_en;
    if (fifo_rd_en && fifo_empty) bad_rd++;
    if (port_valid) begin
      beats.push_back(port_data);
      beat_cyc.push_back(cyc);
    end
    if (parity_err) begin pe_cnt++; pe_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
  end

  always @(posedge clk) begin
    #1;
    if (rd_seen && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    refresh();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    beats.delete();
    beat_cyc.delete();
    pops = 0; pe_cnt = 0; fe_cnt = 0;
    pe_cyc = -1; fe_cyc = -1; bad_rd = 0;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_beats(input string nm, input logic [7:0] exp[$]);
    check({nm, " beat count"}, beats.size(), exp.size());
    if (beats.size() == exp.size())
      foreach (exp[i]) check({nm, " beat"}, beats[i], exp[i]);
  endtask

  task automatic wait_beats(input int n, input int lim);
    int k = 0;
    while (beats.size() < n && k < lim) begin
      step();
      k++;
    end
    if (beats.size() < n) begin
      checks++;
      fails++;
      $display("FAIL wait_beats: got %0d beats expected %0d",
               beats.size(), n);
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] b[5];
    logic       exp_perr;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [7:0] exp[$];
    int         nperr, total;

    vt[0] = '{n: 4, b: '{8'h03, 8'hAA, 8'h55, 8'hFF, 8'h00}, exp_perr: 1'b0};
    vt[1] = '{n: 3, b: '{8'h02, 8'h12, 8'h34, 8'h00, 8'h00}, exp_perr: 1'b1};
    vt[2] = '{n: 1, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, exp_perr: 1'b0};
    vt[3] = '{n: 2, b: '{8'h01, 8'h7E, 8'h00, 8'h00, 8'h00}, exp_perr: 1'b1};

    // reset state
    repeat (3) step();
    check("rst valid", port_valid, 0);
    check("rst data", port_data, 0);
    check("rst busy", busy, 0);
    check("rst perr", parity_err, 0);
    check("rst ferr", frame_err, 0);
    rst_n = 1'b1;
    step();

    // directed frame table
    for (int v = 0; v < 4; v++) begin
      clear();
      exp.delete();
      exp.push_back(8'hFF);
      exp.push_back(port_addr);
      for (int i = 0; i < vt[v].n; i++) begin
        push(vt[v].b[i]);
        exp.push_back(vt[v].b[i]);
      end
      port_rd = 1'b1;
      step();
      port_rd = 1'b0;
      wait_beats(vt[v].n + 2, 100);
      repeat (4) step();
      check_beats("vec", exp);
      if (beats.size() == vt[v].n + 2) begin
        check("vec consecutive", beat_cyc[vt[v].n + 1] - beat_cyc[0],
              vt[v].n + 1);
        if (vt[v].exp_perr)
          check("vec perr in gap", pe_cyc, beat_cyc[vt[v].n + 1] + 1);
      end
      check("vec perr", pe_cnt, vt[v].exp_perr);
      check("vec pops", pops, vt[v].n);
      check("vec ferr", fe_cnt, 0);
      check("vec busy end", busy, 0);
    end

    // underrun timeout: LEN=4 but only two payload bytes
    clear();
    push(8'h04); push(8'h01); push(8'h02);
    port_rd = 1'b1;
    step();
    port_rd = 1'b0;
    wait_beats(5, 50);
    begin
      int k = 0;
      while (fe_cnt == 0 && k < 60) begin step(); k++; end
    end
    check("to ferr", fe_cnt, 1);
    if (beats.size() == 5)
      check("to low cycles", fe_cyc - beat_cyc[4], TO);
    step();
    check("to beats", beats.size(), 5);
    check("to busy", busy, 0);
    check("to bad_rd", bad_rd, 0);
    check("to pops", pops, 3);

    // mid-payload stall of 3 cycles, then resume
    clear();
    exp = '{8'hFF, port_addr, 8'h03, 8'h11, 8'h22, 8'h33};
    push(8'h03); push(8'h11);
    port_rd = 1'b1;
    step();
    port_rd = 1'b0;
    wait_beats(4, 50);
    repeat (3) step();
    push(8'h22); push(8'h33);
    wait_beats(6, 50);
    repeat (3) step();
    check_beats("stall", exp);
    check("stall ferr", fe_cnt, 0);
    check("stall perr", pe_cnt, 0);
    check("stall bad_rd", bad_rd, 0);

    // back-to-back frames, port_rd held
    clear();
    exp = '{8'hFF, port_addr, 8'h01, 8'hAA,
            8'hFF, port_addr, 8'h01, 8'hBB};
    push(8'h01); push(8'hAA); push(8'h01); push(8'hBB);
    port_rd = 1'b1;
    wait_beats(8, 100);
    repeat (3) step();
    port_rd = 1'b0;
    check_beats("b2b", exp);
    if (beats.size() == 8)
      check("b2b gap", beat_cyc[4] - beat_cyc[3], 3);
    check("b2b perr", pe_cnt, 2);
    check("b2b pops", pops, 4);

    // async reset mid-DATA
    clear();
    push(8'h05);
    for (int i = 1; i <= 5; i++) push(8'(i));
    port_rd = 1'b1;
    step();
    port_rd = 1'b0;
    wait_beats(4, 50);
    rst_n = 1'b0;
    #1;
    check("mid rst valid", port_valid, 0);
    check("mid rst data", port_data, 0);
    check("mid rst busy", busy, 0);
    check("mid rst rd_en", fifo_rd_en, 0);
    step();
    rst_n = 1'b1;
    clear();
    repeat (6) step();
    check("post rst beats", beats.size(), 0);
    check("post rst busy", busy, 0);
    fq.delete();
    refresh();
    step();

    // random frames vs byte-stream reference
    clear();
    exp.delete();
    port_addr = 8'($urandom);
    nperr = 0;
    total = 0;
    port_rd = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int         len;
      logic [7:0] x;
      len = $urandom_range(0, 8);
      x = 8'h00;
      push(8'(len));
      total++;
      exp.push_back(8'hFF);
      exp.push_back(port_addr);
      exp.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
        push(b);
        total++;
        x ^= b;
        exp.push_back(b);
      end
      if (x != 8'h00) nperr++;
      repeat ($urandom_range(0, 3)) step();
    end
    wait_beats(exp.size(), 3000);
    repeat (4) step();
    port_rd = 1'b0;
    check_beats("rand", exp);
    check("rand perr", pe_cnt, nperr);
    check("rand ferr", fe_cnt, 0);
    check("rand pops", pops, total);
    check("rand bad_rd", bad_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
